// File: rtl/fir_mac_sched.sv
// fir_mac_sched: time-multiplexed FIR controller.
// One 16x16 signed multiply-accumulate is reused over NTAP taps for each
// input sample. The block holds the coefficient store and a circular sample
// delay line, steps through the taps, and presents each result on an
// AXI-Stream master port. After reset it sweeps both stores to zero.
//
// Per-sample occupancy is one IDLE cycle, NTAP MAC cycles and at least one
// OUT cycle, so with the sink always ready a new sample is taken every
// NTAP+2 cycles. Every output is decoded from registered state or taken
// straight from a register, so no input reaches an output combinationally.
module fir_mac_sched #(
    parameter int NTAP = 16,
    localparam int AW = $clog2(NTAP)
) (
    input  logic                 clk,
    input  logic                 rst_n,

    // Coefficient store write port; honoured only while idle
    input  logic                 coef_we,
    input  logic [AW-1:0]        coef_addr,
    input  logic signed [15:0]   coef_din,

    // Sample input stream
    input  logic signed [15:0]   s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,

    // Filter output stream
    output logic signed [31:0]   m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,

    output logic                 busy
);

    // Index of the last tap; it also ends the clearing sweep.
    localparam logic [AW-1:0] TAP_LAST = AW'(NTAP - 1);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_MAC  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Sequencing registers
    logic [AW-1:0]      init_cnt_reg;   // entry cleared by the sweep
    logic [AW-1:0]      k_reg;          // current tap index
    logic [AW-1:0]      wr_ptr_reg;     // delay-line slot of the newest sample
    logic signed [31:0] acc_reg;        // running sum, wraps modulo 2^32

    // Coefficient store and delay line. Both use a synchronous write and an
    // asynchronous read, which maps to distributed RAM.
    logic signed [15:0] coef_mem  [NTAP];
    logic signed [15:0] delay_mem [NTAP];

    // Strobes decoded from the FSM
    logic init_we;      // sweep is clearing entry init_cnt_reg this cycle
    logic coef_wr;      // external coefficient write is accepted
    logic accept;       // sample handshake on the input stream
    logic mac_en;       // one tap is accumulated this cycle
    logic out_done;     // result handshake on the output stream

    // Datapath
    logic [AW-1:0]      rd_idx;
    logic signed [15:0] coef_rd;
    logic signed [15:0] samp_rd;
    logic signed [31:0] coef_ext;
    logic signed [31:0] samp_ext;
    logic signed [31:0] prod;
    logic signed [31:0] acc_sum;

    // FSM state register; reset always restarts the clearing sweep
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic and per-cycle strobes
    always_comb begin
        state_next = state_reg;
        init_we    = 1'b0;
        coef_wr    = 1'b0;
        accept     = 1'b0;
        mac_en     = 1'b0;
        out_done   = 1'b0;
        case (state_reg)
            ST_INIT: begin
                init_we = rst_n;
                if (init_cnt_reg == TAP_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // The coefficient write and the sample accept share a cycle
                // safely: taps are read only from the next cycle onwards.
                coef_wr = coef_we & rst_n;
                if (s_axis_tvalid) begin
                    accept     = rst_n;
                    state_next = ST_MAC;
                end
            end
            ST_MAC: begin
                mac_en = 1'b1;
                if (k_reg == TAP_LAST) begin
                    state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                if (m_axis_tready) begin
                    out_done   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    // Clearing-sweep counter; it wraps back to zero as the sweep ends
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_cnt_reg <= '0;
        end else if (init_we) begin
            init_cnt_reg <= init_cnt_reg + 1'b1;
        end
    end

    // Tap counter: restarts on each accepted sample and steps once per MAC cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_reg <= '0;
        end else if (accept) begin
            k_reg <= '0;
        end else if (mac_en) begin
            k_reg <= k_reg + 1'b1;
        end
    end

    // Write pointer advances once the result leaves, and wraps with no bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
        end else if (out_done) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
    end

    // The tap-k sample is x[n-k]. The AW-bit subtraction wraps the index
    // modulo NTAP.
    assign rd_idx   = wr_ptr_reg - k_reg;
    assign coef_rd  = coef_mem[k_reg];
    assign samp_rd  = delay_mem[rd_idx];

    // Sign-extend both operands to 32 bits. The low 32 bits of that product
    // are the exact 16x16 signed product.
    assign coef_ext = 32'(coef_rd);
    assign samp_ext = 32'(samp_rd);
    assign prod     = coef_ext * samp_ext;
    assign acc_sum  = acc_reg + prod;

    // Accumulator: cleared on accept, adds one product per MAC cycle, holds in OUT
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else if (accept) begin
            acc_reg <= '0;
        end else if (mac_en) begin
            acc_reg <= acc_sum;
        end
    end

    // Coefficient store: the clearing sweep takes priority over external writes
    always_ff @(posedge clk) begin
        if (init_we) begin
            coef_mem[init_cnt_reg] <= '0;
        end else if (coef_wr) begin
            coef_mem[coef_addr] <= coef_din;
        end
    end

    // Delay line: cleared by the sweep, then written once per accepted sample
    always_ff @(posedge clk) begin
        if (init_we) begin
            delay_mem[init_cnt_reg] <= '0;
        end else if (accept) begin
            delay_mem[wr_ptr_reg] <= s_axis_tdata;
        end
    end

    // Outputs decoded from the state register. The result comes straight
    // from the accumulator, which does not change while in OUT.
    assign s_axis_tready = (state_reg == ST_IDLE);
    assign m_axis_tvalid = (state_reg == ST_OUT);
    assign m_axis_tdata  = acc_reg;
    assign busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_fir_mac_sched.sv
// Self-checking bench for fir_mac_sched, run with NTAP=4.
// A reference model (coefficient copy, delay-line copy, write pointer) works
// out each expected output when a sample is accepted and pushes it to exp_q.
// A monitor pops exp_q and compares on every output handshake.
module tb_fir_mac_sched;

    localparam int NTAP = 4;
    localparam int AW   = $clog2(NTAP);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                coef_we = 1'b0;
    logic [AW-1:0]       coef_addr = '0;
    logic signed [15:0]  coef_din = '0;
    logic signed [15:0]  s_axis_tdata = '0;
    logic                s_axis_tvalid = 1'b0;
    logic                s_axis_tready;
    logic signed [31:0]  m_axis_tdata;
    logic                m_axis_tvalid;
    logic                m_axis_tready = 1'b1;
    logic                busy;

    fir_mac_sched #(.NTAP(NTAP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .coef_we       (coef_we),
        .coef_addr     (coef_addr),
        .coef_din      (coef_din),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int last_wait = 0;

    // Reference model state
    int          m_coef  [NTAP];
    int          m_delay [NTAP];
    int          m_wptr = 0;
    logic [31:0] exp_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NTAP; i++) begin
            m_coef[i]  = 0;
            m_delay[i] = 0;
        end
        m_wptr = 0;
        exp_q.delete();
    endtask

    // Compute the output for new sample x and push it to the scoreboard
    task automatic model_push(input int x);
        longint s;
        s = 0;
        m_delay[m_wptr] = x;
        for (int k = 0; k < NTAP; k++) begin
            s += longint'(m_coef[k]) * longint'(m_delay[(m_wptr - k + NTAP) % NTAP]);
        end
        exp_q.push_back(s[31:0]);
        m_wptr = (m_wptr + 1) % NTAP;
    endtask

    // Scoreboard monitor: one line per output handshake
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_n && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL out_unexpected got=%h exp=none", m_axis_tdata);
            end else begin
                e = exp_q.pop_front();
                if (m_axis_tdata !== e) begin
                    bad++;
                    $display("FAIL out_data got=%h exp=%h", m_axis_tdata, e);
                end else begin
                    $display("out  tdata=%h (cycle %0d)", m_axis_tdata, cyc);
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        s_axis_tvalid = 1'b0;
        coef_we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    // Check the clearing sweep right after rst_n rises: 4 cycles not ready, then ready
    task automatic check_init_sweep();
        total++;
        if (s_axis_tready !== 1'b0 || busy !== 1'b1 || m_axis_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL init_start got rdy=%b busy=%b vld=%b exp rdy=0 busy=1 vld=0",
                     s_axis_tready, busy, m_axis_tvalid);
        end
        for (int i = 1; i <= NTAP; i++) begin
            step();
            total++;
            if (i < NTAP) begin
                if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin
                    bad++;
                    $display("FAIL init_cycle%0d got rdy=%b vld=%b exp rdy=0 vld=0",
                             i, s_axis_tready, m_axis_tvalid);
                end
            end else begin
                if (s_axis_tready !== 1'b1 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL init_done got rdy=%b busy=%b exp rdy=1 busy=0",
                             s_axis_tready, busy);
                end
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (s_axis_tready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        if (s_axis_tready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL idle_timeout got rdy=%b exp=1", s_axis_tready);
        end
    endtask

    task automatic write_coef(input int k, input int v);
        wait_idle();
        coef_we   = 1'b1;
        coef_addr = AW'(k);
        coef_din  = 16'(v);
        m_coef[k] = v;
        step();
        coef_we = 1'b0;
        $display("coef k=%0d v=%0d", k, v);
    endtask

    // Offer sample x; optionally write coefficient a=d in the accept cycle.
    // Returns at the position right after the accept edge.
    task automatic send_sample(input int x, input bit we, input int a, input int d,
                               output int acc_cyc);
        int n;
        n = 0;
        s_axis_tdata  = 16'(x);
        s_axis_tvalid = 1'b1;
        while (s_axis_tready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        last_wait = n;
        if (s_axis_tready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL accept_timeout got rdy=%b exp=1", s_axis_tready);
            s_axis_tvalid = 1'b0;
            acc_cyc = -1;
            return;
        end
        if (we) begin
            coef_we   = 1'b1;
            coef_addr = AW'(a);
            coef_din  = 16'(d);
            m_coef[a] = d;
        end
        model_push(x);
        step();
        acc_cyc = cyc;
        s_axis_tvalid = 1'b0;
        coef_we = 1'b0;
        $display("in   x=%0d accepted (cycle %0d)", x, acc_cyc);
    endtask

    // Wait for m_axis_tvalid; n = edges waited since the call
    task automatic wait_out(output int n);
        n = 0;
        while (m_axis_tvalid !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        if (m_axis_tvalid !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL out_timeout got vld=%b exp=1", m_axis_tvalid);
        end
    endtask

    task automatic test_reset();
        int c, n;
        do_reset();
        total++;
        if (m_axis_tdata !== 32'sd0) begin
            bad++;
            $display("FAIL reset_tdata got=%h exp=0", m_axis_tdata);
        end
        // Writes offered during the clearing sweep must be dropped
        coef_we = 1'b1;
        coef_addr = '0;
        coef_din = 16'sd55;
        check_init_sweep();
        coef_we = 1'b0;
        send_sample(100, 1'b0, 0, 0, c);
        wait_out(n);
        total++;
        if (n !== NTAP) begin
            bad++;
            $display("FAIL reset_latency got=%0d exp=%0d", n, NTAP);
        end
    endtask

    // Impulse through coefs 1..4: checks latency, throughput and delay-line wrap
    task automatic test_impulse();
        int c, prev, n;
        int xs[5] = '{1, 0, 0, 0, 0};
        do_reset();
        wait_idle();
        for (int k = 0; k < NTAP; k++) write_coef(k, k + 1);
        prev = -1;
        for (int i = 0; i < 5; i++) begin
            send_sample(xs[i], 1'b0, 0, 0, c);
            if (prev >= 0) begin
                total++;
                if (c - prev !== NTAP + 2) begin
                    bad++;
                    $display("FAIL throughput got=%0d exp=%0d", c - prev, NTAP + 2);
                end
            end
            prev = c;
            wait_out(n);
            total++;
            if (n !== NTAP) begin
                bad++;
                $display("FAIL impulse_latency got=%0d exp=%0d", n, NTAP);
            end
        end
    endtask

    task automatic test_wrap();
        int c, n;
        do_reset();
        wait_idle();
        for (int k = 0; k < NTAP; k++) write_coef(k, 32767);
        for (int i = 0; i < 4; i++) begin
            send_sample(-32768, 1'b0, 0, 0, c);
            wait_out(n);
        end
    endtask

    task automatic test_backpressure();
        int c, n;
        wait_idle();
        m_axis_tready = 1'b0;
        send_sample(1234, 1'b0, 0, 0, c);
        wait_out(n);
        // Next sample is already offered while the output is stalled
        s_axis_tdata  = -16'sd5;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL hold_queue got=empty exp=one entry");
            end else if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_q[0]
                         || s_axis_tready !== 1'b0) begin
                bad++;
                $display("FAIL hold_cycle%0d got vld=%b data=%h rdy=%b exp vld=1 data=%h rdy=0",
                         i, m_axis_tvalid, m_axis_tdata, s_axis_tready, exp_q[0]);
            end
            step();
        end
        m_axis_tready = 1'b1;
        send_sample(-5, 1'b0, 0, 0, c);
        total++;
        if (last_wait !== 1) begin
            bad++;
            $display("FAIL release_accept got=%0d exp=1", last_wait);
        end
        wait_out(n);
    endtask

    task automatic test_coef_write();
        int c, n;
        do_reset();
        wait_idle();
        for (int k = 0; k < NTAP; k++) write_coef(k, k + 1);
        send_sample(5, 1'b0, 0, 0, c);
        // Write during MAC: must be ignored (model untouched)
        coef_we = 1'b1;
        coef_addr = '0;
        coef_din = 16'sd9;
        step();
        step();
        coef_we = 1'b0;
        wait_out(n);
        send_sample(7, 1'b0, 0, 0, c);
        wait_out(n);
        // Write together with an accept in IDLE: applies to this very sample
        send_sample(11, 1'b1, 0, 9, c);
        wait_out(n);
        send_sample(13, 1'b0, 0, 0, c);
        wait_out(n);
    endtask

    task automatic test_reset_mid_mac();
        int c, n;
        wait_idle();
        send_sample(3, 1'b0, 0, 0, c);
        step();
        step();
        rst_n = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (m_axis_tvalid !== 1'b0) begin
                bad++;
                $display("FAIL rst_vld got=%b exp=0", m_axis_tvalid);
            end
        end
        rst_n = 1'b1;
        model_clear();
        check_init_sweep();
        for (int i = 0; i < 4; i++) begin
            send_sample((i == 0) ? 1 : 0, 1'b0, 0, 0, c);
            wait_out(n);
        end
        for (int k = 0; k < NTAP; k++) write_coef(k, k + 1);
        send_sample(2, 1'b0, 0, 0, c);
        wait_out(n);
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_wrap();
        test_backpressure();
        test_coef_write();
        test_reset_mid_mac();
        step();
        step();
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL leftover got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
